rob: RTL and testbench

Reorder buffer for the out-of-order core. It allocates entries in program order at dispatch and records results broadcast on the CDB. It presents the head entry to `stage_rt` as `rob_retire_packet` / `rob_valid` / `rob_ready`, and frees that entry when it retires. A branch mispredict flushes the whole buffer in one cycle.

---
 rtl/rob.sv | 112 +++++++++++
 tb/tb_rob.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: in-order allocate at dispatch, out-of-order CDB completion, in-order retire of the head.
// Outputs decode registered state only; mispredict flushes every entry in one cycle.
module rob #(
    parameter int DEPTH = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         branch_mispredict,
    input  logic         dispatch_valid,
    input  logic [4:0]   dispatch_dest_reg,
    input  logic         dispatch_reg_valid,
    input  logic         dispatch_is_mem,
    output logic [5:0]   dispatch_tag,
    output logic         rob_full,
    input  logic         cdb_valid,
    input  logic [5:0]   cdb_tag,
    input  logic [63:0]  cdb_value,
    input  logic [63:0]  cdb_mem_addr,
    // {tag[5:0], dest_reg[4:0], value[63:0], reg_valid, mem_valid, mem_addr[63:0]}
    output logic [140:0] rob_retire_packet,
    output logic         rob_valid,
    output logic         rob_ready,
    output logic [6:0]   rob_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [6:0]    count;

    logic          busy      [DEPTH];
    logic          complete  [DEPTH];
    logic [4:0]    dest_reg  [DEPTH];
    logic          reg_valid [DEPTH];
    logic          mem_valid [DEPTH];
    logic [63:0]   value     [DEPTH];
    logic [63:0]   mem_addr  [DEPTH];

    logic          do_dispatch;
    logic          do_complete;
    logic          do_retire;
    logic [AW-1:0] cdb_idx;

    assign cdb_idx = cdb_tag[AW-1:0];

    always_comb begin
        rob_valid         = busy[head];
        rob_ready         = busy[head] && complete[head];
        rob_full          = (count == 7'(DEPTH));
        rob_count         = count;
        dispatch_tag      = 6'(tail);
        rob_retire_packet = '0;
        if (busy[head]) begin
            rob_retire_packet = {6'(head), dest_reg[head], value[head],
                                 reg_valid[head], mem_valid[head], mem_addr[head]};
        end
    end

    // Out-of-range tags must be rejected before the truncated index is used.
    always_comb begin
        do_dispatch = dispatch_valid && !rob_full;
        do_retire   = rob_valid && rob_ready;
        do_complete = cdb_valid && ({1'b0, cdb_tag} < 7'(DEPTH)) && busy[cdb_idx];
    end

    always_ff @(posedge clock) begin
        if (reset || branch_mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy[i]      <= 1'b0;
                complete[i]  <= 1'b0;
                dest_reg[i]  <= '0;
                reg_valid[i] <= 1'b0;
                mem_valid[i] <= 1'b0;
                value[i]     <= '0;
                mem_addr[i]  <= '0;
            end
        end else begin
            if (do_complete) begin
                complete[cdb_idx] <= 1'b1;
                value[cdb_idx]    <= cdb_value;
                if (mem_valid[cdb_idx]) begin
                    mem_addr[cdb_idx] <= cdb_mem_addr;
                end
            end
            if (do_dispatch) begin
                busy[tail]      <= 1'b1;
                complete[tail]  <= 1'b0;
                dest_reg[tail]  <= dispatch_dest_reg;
                reg_valid[tail] <= dispatch_reg_valid;
                mem_valid[tail] <= dispatch_is_mem;
                value[tail]     <= '0;
                mem_addr[tail]  <= '0;
                tail            <= tail + AW'(1);
            end
            // Retire is written last so a late repeat completion cannot revive the freed head.
            if (do_retire) begin
                busy[head]      <= 1'b0;
                complete[head]  <= 1'b0;
                dest_reg[head]  <= '0;
                reg_valid[head] <= 1'b0;
                mem_valid[head] <= 1'b0;
                value[head]     <= '0;
                mem_addr[head]  <= '0;
                head            <= head + AW'(1);
            end
            count <= count + {6'd0, do_dispatch} - {6'd0, do_retire};
        end
    end
endmodule

// File: tb/tb_rob.sv
// Bench for rob (DEPTH=4): scenario tasks with inline checks plus a retire scoreboard
// that pops the expected tag in program order whenever the head is about to retire.
module tb_rob;
    logic         clock = 1'b0;
    logic         reset;
    logic         branch_mispredict;
    logic         dispatch_valid;
    logic [4:0]   dispatch_dest_reg;
    logic         dispatch_reg_valid;
    logic         dispatch_is_mem;
    logic [5:0]   dispatch_tag;
    logic         rob_full;
    logic         cdb_valid;
    logic [5:0]   cdb_tag;
    logic [63:0]  cdb_value;
    logic [63:0]  cdb_mem_addr;
    logic [140:0] rob_retire_packet;
    logic         rob_valid;
    logic         rob_ready;
    logic [6:0]   rob_count;

    int checks = 0;
    int failures = 0;

    // Reference contents per tag, filled by the scenarios as stimulus is driven.
    logic [4:0]  m_dest [64];
    logic        m_rv   [64];
    logic        m_mem  [64];
    logic [63:0] m_val  [64];
    logic [63:0] m_addr [64];
    int          exp_q[$];

    rob #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .branch_mispredict(branch_mispredict),
        .dispatch_valid(dispatch_valid), .dispatch_dest_reg(dispatch_dest_reg),
        .dispatch_reg_valid(dispatch_reg_valid), .dispatch_is_mem(dispatch_is_mem),
        .dispatch_tag(dispatch_tag), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mem_addr(cdb_mem_addr), .rob_retire_packet(rob_retire_packet),
        .rob_valid(rob_valid), .rob_ready(rob_ready), .rob_count(rob_count)
    );

    always #5 clock = ~clock;

    // Scoreboard consumer: valid && ready before an edge means the head retires on it.
    int           sb_tag;
    logic [140:0] sb_exp;
    always @(negedge clock) begin
        if (reset === 1'b0 && branch_mispredict === 1'b0 && rob_valid === 1'b1 && rob_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL retire_unexpected got=%h required=none", rob_retire_packet);
            end else begin
                sb_tag = exp_q.pop_front();
                sb_exp = {6'(sb_tag), m_dest[sb_tag], m_val[sb_tag], m_rv[sb_tag], m_mem[sb_tag], m_addr[sb_tag]};
                if (rob_retire_packet !== sb_exp) begin
                    failures++;
                    $display("FAIL retire_packet tag=%0d got=%h required=%h", sb_tag, rob_retire_packet, sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; branch_mispredict = 1'b0;
        dispatch_valid = 1'b0; dispatch_dest_reg = '0; dispatch_reg_valid = 1'b0; dispatch_is_mem = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mem_addr = '0;
    endtask

    task automatic drive_dispatch(input int tag, input logic [4:0] dest, input logic rv, input logic mem);
        dispatch_valid = 1'b1; dispatch_dest_reg = dest; dispatch_reg_valid = rv; dispatch_is_mem = mem;
        m_dest[tag] = dest; m_rv[tag] = rv; m_mem[tag] = mem; m_val[tag] = '0; m_addr[tag] = '0;
        exp_q.push_back(tag);
    endtask

    task automatic drive_cdb(input int tag, input logic [63:0] val, input logic [63:0] addr);
        cdb_valid = 1'b1; cdb_tag = 6'(tag); cdb_value = val; cdb_mem_addr = addr;
        m_val[tag] = val;
        if (m_mem[tag]) m_addr[tag] = addr;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rob_valid !== 1'b0 || rob_ready !== 1'b0 || rob_full !== 1'b0 || rob_count !== 7'd0 ||
                dispatch_tag !== 6'd0 || rob_retire_packet !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got v=%b r=%b f=%b cnt=%0d tag=%0d pkt=%h required all zero",
                         i, rob_valid, rob_ready, rob_full, rob_count, dispatch_tag, rob_retire_packet);
            end
        end
    endtask

    task automatic test_basic();
        drive_dispatch(0, 5'd5, 1'b1, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (rob_valid !== 1'b1 || rob_ready !== 1'b0 || rob_count !== 7'd1) begin
            failures++;
            $display("FAIL basic_dispatched got v=%b r=%b cnt=%0d required v=1 r=0 cnt=1", rob_valid, rob_ready, rob_count);
        end
        drive_cdb(0, 64'h1111_1111_1111_1111, 64'hDEAD_BEEF);
        tick();
        idle_inputs();
        checks++;
        if (rob_ready !== 1'b1 || rob_retire_packet !== {6'd0, 5'd5, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'd0}) begin
            failures++;
            $display("FAIL basic_complete got r=%b pkt=%h required r=1 pkt=%h", rob_ready, rob_retire_packet,
                     {6'd0, 5'd5, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'd0});
        end
        tick();
        checks++;
        if (rob_count !== 7'd0 || rob_valid !== 1'b0 || dispatch_tag !== 6'd1) begin
            failures++;
            $display("FAIL basic_retired got cnt=%0d v=%b tag=%0d required cnt=0 v=0 tag=1", rob_count, rob_valid, dispatch_tag);
        end
    endtask

    task automatic test_out_of_order();
        drive_dispatch(1, 5'd8, 1'b1, 1'b0);
        tick();
        drive_dispatch(2, 5'd12, 1'b1, 1'b1);
        tick();
        idle_inputs();
        drive_cdb(2, 64'h2222, 64'h8000_0040);
        tick();
        idle_inputs();
        checks++;
        if (rob_ready !== 1'b0 || rob_count !== 7'd2) begin
            failures++;
            $display("FAIL ooo_younger_done got r=%b cnt=%0d required r=0 cnt=2", rob_ready, rob_count);
        end
        tick();
        checks++;
        if (rob_ready !== 1'b0) begin
            failures++;
            $display("FAIL ooo_wait got r=%b required r=0", rob_ready);
        end
        drive_cdb(1, 64'h3333, 64'h0);
        tick();
        idle_inputs();
        checks++;
        if (rob_ready !== 1'b1 || rob_count !== 7'd2) begin
            failures++;
            $display("FAIL ooo_head_done got r=%b cnt=%0d required r=1 cnt=2", rob_ready, rob_count);
        end
        tick();
        checks++;
        if (rob_count !== 7'd1 || rob_retire_packet !== {6'd2, 5'd12, 64'h2222, 1'b1, 1'b1, 64'h8000_0040}) begin
            failures++;
            $display("FAIL ooo_second_head got cnt=%0d pkt=%h required cnt=1 pkt=%h", rob_count, rob_retire_packet,
                     {6'd2, 5'd12, 64'h2222, 1'b1, 1'b1, 64'h8000_0040});
        end
        tick();
        checks++;
        if (rob_count !== 7'd0) begin
            failures++;
            $display("FAIL ooo_drained got cnt=%0d required 0", rob_count);
        end
    endtask

    task automatic test_full_wrap();
        idle_inputs();
        reset = 1'b1;
        tick();
        exp_q.delete();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_dispatch(i, 5'(i + 1), 1'b1, 1'b0);
            else begin
                dispatch_valid = 1'b1; dispatch_dest_reg = 5'd30; dispatch_reg_valid = 1'b1; dispatch_is_mem = 1'b0;
            end
            tick();
            if (i == 3) begin
                checks++;
                if (rob_full !== 1'b1 || rob_count !== 7'd4) begin
                    failures++;
                    $display("FAIL full_after4 got f=%b cnt=%0d required f=1 cnt=4", rob_full, rob_count);
                end
            end
        end
        checks++;
        if (rob_count !== 7'd4 || dispatch_tag !== 6'd0) begin
            failures++;
            $display("FAIL full_5th_ignored got cnt=%0d tag=%0d required cnt=4 tag=0", rob_count, dispatch_tag);
        end
        dispatch_dest_reg = 5'd20;
        drive_cdb(0, 64'hA0, 64'h0);
        tick();
        drive_cdb(1, 64'hA1, 64'h0);
        tick();
        checks++;
        if (rob_count !== 7'd3 || dispatch_tag !== 6'd0 || rob_full !== 1'b0) begin
            failures++;
            $display("FAIL full_retire_reject got cnt=%0d tag=%0d f=%b required cnt=3 tag=0 f=0", rob_count, dispatch_tag, rob_full);
        end
        idle_inputs();
        drive_cdb(2, 64'hA2, 64'h0);
        tick();
        idle_inputs();
        drive_cdb(3, 64'hA3, 64'h0);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (rob_count !== 7'd0 || rob_valid !== 1'b0 || dispatch_tag !== 6'd0) begin
            failures++;
            $display("FAIL wrap_empty got cnt=%0d v=%b tag=%0d required cnt=0 v=0 tag=0", rob_count, rob_valid, dispatch_tag);
        end
        // Dispatch into the empty buffer with a same-edge CDB write that must be dropped.
        drive_dispatch(0, 5'd9, 1'b1, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_value = 64'hBAD;
        tick();
        idle_inputs();
        checks++;
        if (rob_ready !== 1'b0 || rob_retire_packet !== {6'd0, 5'd9, 64'd0, 1'b1, 1'b0, 64'd0}) begin
            failures++;
            $display("FAIL wrap_same_edge_cdb got r=%b pkt=%h required r=0 pkt=%h", rob_ready, rob_retire_packet,
                     {6'd0, 5'd9, 64'd0, 1'b1, 1'b0, 64'd0});
        end
        drive_cdb(0, 64'hC0, 64'h0);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (rob_count !== 7'd0 || dispatch_tag !== 6'd1) begin
            failures++;
            $display("FAIL wrap_drained got cnt=%0d tag=%0d required cnt=0 tag=1", rob_count, dispatch_tag);
        end
    endtask

    task automatic test_mispredict();
        drive_dispatch(1, 5'd1, 1'b1, 1'b0);
        tick();
        drive_dispatch(2, 5'd2, 1'b1, 1'b0);
        tick();
        drive_dispatch(3, 5'd3, 1'b1, 1'b1);
        tick();
        idle_inputs();
        drive_cdb(2, 64'h55, 64'h0);
        tick();
        idle_inputs();
        branch_mispredict = 1'b1;
        dispatch_valid = 1'b1; dispatch_dest_reg = 5'd7; dispatch_reg_valid = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_value = 64'h66; cdb_mem_addr = 64'h70;
        tick();
        idle_inputs();
        exp_q.delete();
        checks++;
        if (rob_count !== 7'd0 || rob_valid !== 1'b0 || rob_ready !== 1'b0 || dispatch_tag !== 6'd0 ||
            rob_full !== 1'b0 || rob_retire_packet !== '0) begin
            failures++;
            $display("FAIL mispredict_flush got cnt=%0d v=%b r=%b tag=%0d f=%b pkt=%h required all zero",
                     rob_count, rob_valid, rob_ready, dispatch_tag, rob_full, rob_retire_packet);
        end
        drive_dispatch(0, 5'd12, 1'b1, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (rob_count !== 7'd1 || rob_retire_packet !== {6'd0, 5'd12, 64'd0, 1'b1, 1'b0, 64'd0}) begin
            failures++;
            $display("FAIL mispredict_redispatch got cnt=%0d pkt=%h required cnt=1 pkt=%h", rob_count, rob_retire_packet,
                     {6'd0, 5'd12, 64'd0, 1'b1, 1'b0, 64'd0});
        end
        drive_cdb(0, 64'h77, 64'h0);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_stray_cdb();
        drive_dispatch(1, 5'd3, 1'b1, 1'b1);
        tick();
        idle_inputs();
        cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_value = 64'hFF; cdb_mem_addr = 64'hFF;
        tick();
        idle_inputs();
        checks++;
        if (rob_count !== 7'd1 || rob_ready !== 1'b0 || dispatch_tag !== 6'd2 ||
            rob_retire_packet !== {6'd1, 5'd3, 64'd0, 1'b1, 1'b1, 64'd0}) begin
            failures++;
            $display("FAIL stray_tag7 got cnt=%0d r=%b tag=%0d pkt=%h required cnt=1 r=0 tag=2 pkt=%h", rob_count,
                     rob_ready, dispatch_tag, rob_retire_packet, {6'd1, 5'd3, 64'd0, 1'b1, 1'b1, 64'd0});
        end
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_value = 64'hEE; cdb_mem_addr = 64'hEE;
        tick();
        idle_inputs();
        checks++;
        if (rob_count !== 7'd1 || rob_ready !== 1'b0 || rob_retire_packet !== {6'd1, 5'd3, 64'd0, 1'b1, 1'b1, 64'd0}) begin
            failures++;
            $display("FAIL stray_unbusy got cnt=%0d r=%b pkt=%h required cnt=1 r=0", rob_count, rob_ready, rob_retire_packet);
        end
        drive_cdb(1, 64'h99, 64'h1234);
        tick();
        idle_inputs();
        checks++;
        if (rob_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_then_complete got r=%b required r=1", rob_ready);
        end
        tick();
        checks++;
        if (rob_count !== 7'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_drain got cnt=%0d pending=%0d required cnt=0 pending=0", rob_count, exp_q.size());
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_out_of_order();
        test_full_wrap();
        test_mispredict();
        test_stray_cdb();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
